// File: rtl/text_mem_arbiter_pkg.sv
// Shared text-mode constants and arbiter FSM encoding, also used by the
// scanout timing logic.
package text_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned COLS   = 100;
  localparam int unsigned ROWS   = 75;
  localparam int unsigned LIMIT  = COLS * ROWS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/text_mem_arbiter_fill_counter.sv
// Screen-fill address counter: synchronous clear, stalls on !i_en, and
// saturates at LIMIT-1 so it never wraps.
module fill_counter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LIMIT  = 7500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LIMIT - 1);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/text_mem_arbiter.sv
// Single-port text RAM arbiter: scanout reads beat screen fill, which beats
// CPU writes. Out-of-range CPU writes are accepted and flagged via wr_drop.
module text_mem_arbiter #(
  parameter int unsigned ADDR_W = text_mem_arbiter_pkg::ADDR_W,
  parameter int unsigned COLS   = text_mem_arbiter_pkg::COLS,
  parameter int unsigned ROWS   = text_mem_arbiter_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clr_start,
  input  logic [7:0]        clr_char,
  output logic              clr_busy,
  output logic              wr_drop,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  import text_mem_arbiter_pkg::*;

  localparam int unsigned       LIMIT   = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(LIMIT);

  state_t            r_state;
  logic [7:0]        r_char;
  logic              r_disp_valid;
  logic              r_wr_drop;

  logic [ADDR_W-1:0] w_cnt;
  logic              w_tc;
  logic              w_fill_go;
  logic              w_cnt_clr;
  logic              w_wr_xfer;
  logic              w_wr_inrange;
  logic [7:0]        w_unused_rdata;

  // Read data is consumed by the scanout pipeline outside this block.
  assign w_unused_rdata = mem_rdata;

  assign w_fill_go    = (r_state == ST_FILL) && !disp_req;
  assign w_cnt_clr    = (r_state == ST_IDLE) && clr_start;
  // rst_n is folded in so no CPU write can be granted while reset is held.
  assign wr_ready     = rst_n && (r_state == ST_IDLE) && !disp_req && !clr_start;
  assign w_wr_xfer    = wr_valid && wr_ready;
  assign w_wr_inrange = (wr_addr < LIMIT_A);

  fill_counter #(
    .ADDR_W (ADDR_W),
    .LIMIT  (LIMIT)
  ) u_fill_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_fill_go),
    .i_clr   (w_cnt_clr),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (r_state == ST_FILL) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w_cnt;
      mem_wdata = r_char;
    end else if (w_wr_xfer && w_wr_inrange) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_char       <= '0;
      r_disp_valid <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else begin
      r_disp_valid <= disp_req;
      r_wr_drop    <= w_wr_xfer && !w_wr_inrange;
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state <= ST_FILL;
            r_char  <= clr_char;
          end
        end
        ST_FILL: begin
          if (w_fill_go && w_tc) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign disp_valid = r_disp_valid;
  assign wr_drop    = r_wr_drop;
  assign clr_busy   = (r_state == ST_FILL);

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Scoreboard bench for text_mem_arbiter: expected RAM writes are queued as
// stimulus is driven and retired by a negedge monitor.
module tb_text_mem_arbiter;

  localparam int unsigned AW  = 13;
  localparam int unsigned LIM = 7500;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          clr_start;
  logic [7:0]    clr_char;
  logic          clr_busy;
  logic          wr_drop;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int unsigned   chk;
  int unsigned   err;
  int unsigned   wr_seen;
  logic [20:0]   sb[$];
  logic          prev_req;

  text_mem_arbiter #(
    .ADDR_W (AW),
    .COLS   (100),
    .ROWS   (75)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_start  (clr_start),
    .clr_char   (clr_char),
    .clr_busy   (clr_busy),
    .wr_drop    (wr_drop),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Negedge monitor: retires RAM writes against the scoreboard and checks
  // scanout priority, read latency and idle bus values every cycle.
  always @(negedge clk) begin
    logic [20:0] exp;
    if (mem_en && mem_we) begin
      chk++;
      if (sb.size() == 0) begin
        err++;
        $display("FAIL unexpected_write addr=%h data=%h required no write", mem_addr, mem_wdata);
      end else begin
        exp = sb.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          err++;
          $display("FAIL write_order addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, exp[20:8], exp[7:0]);
        end
      end
      wr_seen++;
    end
    chk++;
    if (!rst_n) begin
      if (disp_valid !== 1'b0) begin
        err++;
        $display("FAIL disp_valid_reset got=%b required=0", disp_valid);
      end
      prev_req = 1'b0;
    end else begin
      if (disp_valid !== prev_req) begin
        err++;
        $display("FAIL disp_valid_latency got=%b required=%b", disp_valid, prev_req);
      end
      prev_req = disp_req;
    end
    if (rst_n && disp_req) begin
      chk++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== disp_addr || wr_ready !== 1'b0) begin
        err++;
        $display("FAIL disp_grant en=%b we=%b addr=%h rdy=%b required en=1 we=0 addr=%h rdy=0",
                 mem_en, mem_we, mem_addr, wr_ready, disp_addr);
      end
    end
    if (mem_en === 1'b0) begin
      chk++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        err++;
        $display("FAIL idle_bus we=%b addr=%h data=%h required we=0 addr=0 data=0",
                 mem_we, mem_addr, mem_wdata);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 8'h11;
    clr_start = 1'b1; clr_char = 8'h20; mem_rdata = '0;
    @(negedge clk);
    chk++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      err++;
      $display("FAIL reset_gating rdy=%b we=%b required rdy=0 we=0", wr_ready, mem_we);
    end
    chk++;
    if (clr_busy !== 1'b0 || wr_drop !== 1'b0 || disp_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_outputs busy=%b drop=%b dv=%b required 0 0 0", clr_busy, wr_drop, disp_valid);
    end
    wr_valid = 1'b0; clr_start = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
      err++;
      $display("FAIL post_reset busy=%b rdy=%b required busy=0 rdy=1", clr_busy, wr_ready);
    end
  endtask

  task automatic test_disp_priority();
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 13'h0123;
    wr_valid = 1'b1; wr_addr = 13'h0064; wr_data = 8'h41;
    @(negedge clk);
    chk++;
    if (wr_ready !== 1'b0 || mem_addr !== 13'h0123 || mem_we !== 1'b0) begin
      err++;
      $display("FAIL disp_over_cpu rdy=%b addr=%h we=%b required rdy=0 addr=0123 we=0",
               wr_ready, mem_addr, mem_we);
    end
    @(posedge clk); #1;
    disp_req = 1'b0;
    sb.push_back({13'h0064, 8'h41});
    @(negedge clk);
    chk++;
    if (disp_valid !== 1'b1) begin
      err++;
      $display("FAIL disp_valid_next got=%b required=1", disp_valid);
    end
    chk++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h0064 || mem_wdata !== 8'h41) begin
      err++;
      $display("FAIL cpu_write rdy=%b we=%b addr=%h data=%h required 1 1 0064 41",
               wr_ready, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk++;
    if (disp_valid !== 1'b0) begin
      err++;
      $display("FAIL disp_valid_drop got=%b required=0", disp_valid);
    end
  endtask

  task automatic test_cpu_boundary();
    logic [AW-1:0] a;
    logic          inr;
    for (int unsigned i = 0; i < 3; i++) begin
      a   = (i == 0) ? 13'd7499 : (i == 1) ? 13'h1D4C : 13'd8191;
      inr = (32'(a) < LIM);
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = a; wr_data = 8'(8'h55 + i);
      if (inr) sb.push_back({a, 8'(8'h55 + i)});
      @(negedge clk);
      chk++;
      if (wr_ready !== 1'b1 || mem_we !== inr) begin
        err++;
        $display("FAIL bound_accept addr=%h rdy=%b we=%b required rdy=1 we=%b", a, wr_ready, mem_we, inr);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(negedge clk);
      chk++;
      if (wr_drop !== !inr) begin
        err++;
        $display("FAIL wr_drop_pulse addr=%h got=%b required=%b", a, wr_drop, !inr);
      end
      @(negedge clk);
      chk++;
      if (wr_drop !== 1'b0) begin
        err++;
        $display("FAIL wr_drop_width addr=%h got=%b required=0", a, wr_drop);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [7:0]    d;
    int unsigned   k;
    k = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      a = AW'(200 + k);
      d = 8'(8'h30 + k);
      disp_req = (i % 3 == 1); disp_addr = AW'(i * 37);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      if (!disp_req) begin
        sb.push_back({a, d});
        k++;
      end
      @(negedge clk);
      chk++;
      if (wr_ready !== !disp_req) begin
        err++;
        $display("FAIL b2b_ready cyc=%0d got=%b required=%b", i, wr_ready, !disp_req);
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL b2b_drain pending=%0d required=0", sb.size());
    end
  endtask

  task automatic run_fill(input logic [7:0] ch, input bit toggle);
    int unsigned n;
    int unsigned busy_cyc;
    int unsigned want;
    bit          done;
    for (int unsigned a = 0; a < LIM; a++) sb.push_back({AW'(a), ch});
    @(posedge clk); #1;
    disp_req = 1'b0; clr_start = 1'b1; clr_char = ch;
    @(negedge clk);
    chk++;
    if (wr_ready !== 1'b0 || clr_busy !== 1'b0) begin
      err++;
      $display("FAIL fill_start rdy=%b busy=%b required rdy=0 busy=0", wr_ready, clr_busy);
    end
    @(posedge clk); #1;
    clr_start = 1'b0; clr_char = 8'hEE;
    n = 0; busy_cyc = 0; done = 1'b0;
    while (!done && n < 20000) begin
      disp_req  = toggle ? n[0] : 1'b0;
      disp_addr = AW'($urandom_range(0, 8191));
      clr_start = (n == 100);
      clr_char  = (n == 100) ? 8'h77 : 8'hEE;
      @(negedge clk); #2;
      if (clr_busy) begin
        busy_cyc++;
        chk++;
        if (wr_ready !== 1'b0) begin
          err++;
          $display("FAIL fill_ready cyc=%0d got=%b required=0", n, wr_ready);
        end
      end else begin
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    disp_req = 1'b0; clr_start = 1'b0;
    want = toggle ? 14999 : LIM;
    chk++;
    if (!done || busy_cyc != want) begin
      err++;
      $display("FAIL fill_length done=%b busy_cycles=%0d required %0d", done, busy_cyc, want);
    end
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL fill_count missing=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_fill();
    run_fill(8'h20, 1'b0);
    run_fill(8'hA7, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    int unsigned base;
    int unsigned guard;
    for (int unsigned a = 0; a < 3000; a++) sb.push_back({AW'(a), 8'h2E});
    base = wr_seen;
    @(posedge clk); #1;
    clr_start = 1'b1; clr_char = 8'h2E;
    @(posedge clk); #1;
    clr_start = 1'b0; clr_char = 8'h00;
    guard = 0;
    while ((wr_seen - base) < 3000 && guard < 10000) begin
      @(negedge clk); #2;
      guard++;
    end
    chk++;
    if ((wr_seen - base) != 3000) begin
      err++;
      $display("FAIL abort_reach writes=%0d required 3000", wr_seen - base);
    end
    rst_n = 1'b0;
    #1;
    chk++;
    if (clr_busy !== 1'b0 || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
      err++;
      $display("FAIL abort_async busy=%b we=%b rdy=%b required 0 0 0", clr_busy, mem_we, wr_ready);
    end
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk++;
    if (clr_busy !== 1'b0 || sb.size() != 0) begin
      err++;
      $display("FAIL abort_after busy=%b pending=%0d required busy=0 pending=0", clr_busy, sb.size());
      sb.delete();
    end
    run_fill(8'h5A, 1'b0);
  endtask

  initial begin
    chk = 0; err = 0; wr_seen = 0; prev_req = 1'b0;
    test_reset();
    test_disp_priority();
    test_cpu_boundary();
    test_back_to_back();
    test_fill();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
